// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life generation sequencer: state encoding,
// default grid height and a constant clog2 helper for port sizing.
package gol_pkg;

  localparam int DEFAULT_ROWS = 720;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_SWAP,
    ST_DONE
  } seq_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/row_neighbour.sv
// Maps the row being computed to its upper and lower neighbours, and flags
// neighbours that fall off the grid when edges are dead rather than toroidal.
module row_neighbour
  import gol_pkg::*;
#(
  parameter int ROWS  = DEFAULT_ROWS,
  parameter int ROW_W = clog2(ROWS)
) (
  input  logic [ROW_W-1:0] row,
  input  logic             wrap,
  output logic [ROW_W-1:0] top_row,
  output logic [ROW_W-1:0] bot_row,
  output logic             top_dead,
  output logic             bot_dead
);

  localparam logic [ROW_W-1:0] LAST = ROW_W'(ROWS - 1);

  always_comb begin
    top_row  = (row == '0)   ? LAST : row - ROW_W'(1);
    bot_row  = (row == LAST) ? '0   : row + ROW_W'(1);
    top_dead = !wrap && (row == '0);
    bot_dead = !wrap && (row == LAST);
  end

endmodule

// File: rtl/generation_sequencer.sv
// Steps the line buffer through every row of each generation, swapping the
// ping-pong banks between generations until the requested count is reached.
//
// state | meaning
// IDLE  | waiting for start; banks and gens_done hold their last values
// ISSUE | pulse row_req for calc_row once pause is low
// WAIT  | waiting for row_valid from the line buffer
// SWAP  | generation finished: toggle banks, count it, restart or finish
// DONE  | one-cycle done pulse, busy already low
module generation_sequencer
  import gol_pkg::*;
#(
  parameter int  ROWS  = DEFAULT_ROWS,
  parameter int  GEN_W = 16,
  localparam int ROW_W = clog2(ROWS)
) (
  input  logic             out_stream_aclk,
  input  logic             out_stream_aresetn,
  input  logic             start,
  input  logic [GEN_W-1:0] gen_count,
  input  logic             wrap_mode,
  input  logic             pause,
  input  logic             row_valid,
  output logic             busy,
  output logic             done,
  output logic             calc_flag,
  output logic             row_req,
  output logic [ROW_W-1:0] calc_row,
  output logic [ROW_W-1:0] top_row,
  output logic [ROW_W-1:0] bot_row,
  output logic             top_dead,
  output logic             bot_dead,
  output logic             read_bank,
  output logic             write_bank,
  output logic [GEN_W-1:0] gens_done,
  output logic             seq_err
);

  localparam logic [ROW_W-1:0] LAST = ROW_W'(ROWS - 1);

  seq_state_t       state, state_nxt;
  logic [GEN_W-1:0] gen_lat, gen_lat_nxt, gens_done_nxt;
  logic [ROW_W-1:0] calc_row_nxt, top_nb, bot_nb;
  logic             wrap_lat, wrap_nxt, top_dead_nb, bot_dead_nb, row_load;
  logic             busy_nxt, done_nxt, calc_flag_nxt, row_req_nxt;
  logic             read_bank_nxt, seq_err_nxt;
  logic             last_row, last_gen;

  assign last_row = (calc_row == LAST);
  assign last_gen = ((gens_done + GEN_W'(1)) == gen_lat);

  always_ff @(posedge out_stream_aclk or negedge out_stream_aresetn) begin
    if (!out_stream_aresetn) begin
      state      <= ST_IDLE;
      gen_lat    <= '0;
      wrap_lat   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      calc_flag  <= 1'b0;
      row_req    <= 1'b0;
      calc_row   <= '0;
      top_row    <= '0;
      bot_row    <= '0;
      top_dead   <= 1'b0;
      bot_dead   <= 1'b0;
      read_bank  <= 1'b0;
      write_bank <= 1'b1;
      gens_done  <= '0;
      seq_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      gen_lat    <= gen_lat_nxt;
      wrap_lat   <= wrap_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      calc_flag  <= calc_flag_nxt;
      row_req    <= row_req_nxt;
      calc_row   <= calc_row_nxt;
      read_bank  <= read_bank_nxt;
      write_bank <= !read_bank_nxt;
      gens_done  <= gens_done_nxt;
      seq_err    <= seq_err_nxt;
      // Neighbour outputs only move with calc_row, so they stay zero after reset.
      if (row_load) begin
        top_row  <= top_nb;
        bot_row  <= bot_nb;
        top_dead <= top_dead_nb;
        bot_dead <= bot_dead_nb;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (gen_count == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (row_req) state_nxt = ST_WAIT;
      ST_WAIT:  if (row_valid) state_nxt = last_row ? ST_SWAP : ST_ISSUE;
      ST_SWAP:  state_nxt = last_gen ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs are computed one cycle ahead so row_req can rise in the
  // cycle right after a start is accepted.
  always_comb begin
    gen_lat_nxt   = gen_lat;
    wrap_nxt      = wrap_lat;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    calc_flag_nxt = calc_flag;
    row_req_nxt   = 1'b0;
    calc_row_nxt  = calc_row;
    row_load      = 1'b0;
    read_bank_nxt = read_bank;
    gens_done_nxt = gens_done;
    seq_err_nxt   = seq_err;
    case (state)
      ST_IDLE: begin
        if (start) begin
          seq_err_nxt = 1'b0;
          if (gen_count == '0) begin
            done_nxt = 1'b1;
          end else begin
            gen_lat_nxt   = gen_count;
            wrap_nxt      = wrap_mode;
            gens_done_nxt = '0;
            calc_row_nxt  = '0;
            row_load      = 1'b1;
            busy_nxt      = 1'b1;
            calc_flag_nxt = 1'b1;
            row_req_nxt   = !pause;
          end
        end
      end
      ST_ISSUE: row_req_nxt = !row_req && !pause;
      ST_WAIT: begin
        if (row_valid && !last_row) begin
          calc_row_nxt = calc_row + ROW_W'(1);
          row_load     = 1'b1;
          row_req_nxt  = !pause;
        end
      end
      ST_SWAP: begin
        read_bank_nxt = !read_bank;
        gens_done_nxt = gens_done + GEN_W'(1);
        if (last_gen) begin
          done_nxt      = 1'b1;
          busy_nxt      = 1'b0;
          calc_flag_nxt = 1'b0;
        end else begin
          calc_row_nxt = '0;
          row_load     = 1'b1;
          row_req_nxt  = !pause;
        end
      end
      default: ;
    endcase
    if (row_valid && state != ST_WAIT) seq_err_nxt = 1'b1;
  end

  row_neighbour #(.ROWS(ROWS), .ROW_W(ROW_W)) u_row_neighbour (
    .row      (calc_row_nxt),
    .wrap     (wrap_nxt),
    .top_row  (top_nb),
    .bot_row  (bot_nb),
    .top_dead (top_dead_nb),
    .bot_dead (bot_dead_nb)
  );

endmodule

// File: tb/tb_generation_sequencer.sv
// Directed scoreboard bench for generation_sequencer with a 4-row grid: stimulus
// queues expected row requests and done pulses, a monitor pops and compares them.
module tb_generation_sequencer;
  localparam int ROWS  = 4;
  localparam int GEN_W = 16;
  localparam int ROW_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [GEN_W-1:0] gen_count = '0;
  logic             wrap_mode = 1'b0;
  logic             pause = 1'b0;
  logic             resp_valid = 1'b0;
  logic             stray_valid = 1'b0;
  logic             row_valid;
  logic             busy, done, calc_flag, row_req, top_dead, bot_dead;
  logic             read_bank, write_bank, seq_err;
  logic [ROW_W-1:0] calc_row, top_row, bot_row;
  logic [GEN_W-1:0] gens_done;

  assign row_valid = resp_valid | stray_valid;

  always #5 clk = ~clk;

  generation_sequencer #(.ROWS(ROWS), .GEN_W(GEN_W)) dut (
    .out_stream_aclk    (clk),
    .out_stream_aresetn (rst_n),
    .start              (start),
    .gen_count          (gen_count),
    .wrap_mode          (wrap_mode),
    .pause              (pause),
    .row_valid          (row_valid),
    .busy               (busy),
    .done               (done),
    .calc_flag          (calc_flag),
    .row_req            (row_req),
    .calc_row           (calc_row),
    .top_row            (top_row),
    .bot_row            (bot_row),
    .top_dead           (top_dead),
    .bot_dead           (bot_dead),
    .read_bank          (read_bank),
    .write_bank         (write_bank),
    .gens_done          (gens_done),
    .seq_err            (seq_err)
  );

  typedef struct {int row; int top; int bot; bit td; bit bd; bit bank;} row_exp_t;
  typedef struct {int gens; bit chk_gens; bit bank;} done_exp_t;

  row_exp_t  exp_rows[$];
  done_exp_t exp_done[$];
  int n_cmp = 0;
  int n_err = 0;
  int rq_cnt = 0;
  int done_cnt = 0;

  // Hand-computed neighbours for a 4-row grid, indexed by calc_row.
  int top_tbl[4] = '{3, 0, 1, 2};
  int bot_tbl[4] = '{1, 2, 3, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_gen(input bit wrap, input bit bank);
    row_exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      e.row  = r;
      e.top  = top_tbl[r];
      e.bot  = bot_tbl[r];
      e.td   = !wrap && (r == 0);
      e.bd   = !wrap && (r == 3);
      e.bank = bank;
      exp_rows.push_back(e);
    end
  endtask

  task automatic push_done(input int gens, input bit chk_gens, input bit bank);
    done_exp_t d;
    d.gens = gens;
    d.chk_gens = chk_gens;
    d.bank = bank;
    exp_done.push_back(d);
  endtask

  task automatic do_start(input int gc, input bit wrap);
    @(posedge clk);
    #1 start = 1'b1;
    gen_count = GEN_W'(gc);
    wrap_mode = wrap;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int base;
    base = done_cnt;
    for (int i = 0; i < 400 && done_cnt == base; i++) @(negedge clk);
    chk({name, "_done_seen"}, done_cnt - base, 1);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_outputs_zero"},
        {busy, done, calc_flag, row_req, calc_row, top_row, bot_row,
         top_dead, bot_dead, read_bank, gens_done, seq_err}, 0);
    chk({name, "_write_bank"}, write_bank, 1);
  endtask

  // Monitor: every row_req or done pulse is matched against the scoreboard.
  initial begin
    row_exp_t  e;
    done_exp_t d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (row_req) begin
          rq_cnt++;
          if (exp_rows.size() == 0) chk("unexpected_row_req", 1, 0);
          else begin
            e = exp_rows.pop_front();
            chk("calc_row", calc_row, e.row);
            chk("top_row", top_row, e.top);
            chk("bot_row", bot_row, e.bot);
            chk("top_dead", top_dead, e.td);
            chk("bot_dead", bot_dead, e.bd);
            chk("read_bank", read_bank, e.bank);
            chk("write_bank", write_bank, !e.bank);
            chk("busy_in_run", {busy, calc_flag}, 2'b11);
          end
        end
        if (done) begin
          done_cnt++;
          if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            d = exp_done.pop_front();
            if (d.chk_gens) chk("gens_done", gens_done, d.gens);
            chk("done_bank", read_bank, d.bank);
            chk("busy_at_done", {busy, calc_flag}, 2'b00);
          end
        end
      end
    end
  end

  // Line buffer model: answers each row_req three cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && row_req) begin
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 resp_valid = 1'b1;
        @(posedge clk);
        #1 resp_valid = 1'b0;
      end
    end
  end

  initial begin
    int  base;
    bit  found;
    repeat (3) @(negedge clk);
    chk_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("after_reset");

    // One generation, dead edges: bank 0 -> 1.
    push_gen(0, 0);
    push_done(1, 1, 1);
    do_start(1, 0);
    @(negedge clk);
    chk("row_req_after_start", row_req, 1);
    wait_run("gen1");
    chk("gen1_rows_left", exp_rows.size(), 0);
    chk("gen1_gens_done", gens_done, 1);
    chk("gen1_read_bank", read_bank, 1);

    // Zero-generation run: done only, banks untouched.
    push_done(1, 1, 1);
    base = rq_cnt;
    do_start(0, 0);
    @(negedge clk);
    chk("zero_done_pulse", done, 1);
    for (int i = 0; i < 3; i++) begin
      chk("zero_busy_low", busy, 0);
      @(negedge clk);
    end
    chk("zero_no_row_req", rq_cnt - base, 0);
    chk("zero_bank_kept", read_bank, 1);

    // Stray row_valid in IDLE sets seq_err and leaves the FSM idle.
    @(posedge clk);
    #1 stray_valid = 1'b1;
    @(posedge clk);
    #1 stray_valid = 1'b0;
    @(negedge clk);
    chk("seq_err_set", seq_err, 1);
    chk("stray_idle", {busy, row_req, done}, 3'b000);

    // Pause held for 5 cycles in ISSUE: bank 1 -> 0.
    push_gen(0, 1);
    push_done(1, 1, 0);
    pause = 1'b1;
    do_start(1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("paused_row_req", row_req, 0);
    end
    chk("seq_err_cleared", seq_err, 0);
    chk("paused_busy", busy, 1);
    pause = 1'b0;
    @(negedge clk);
    chk("row_req_after_pause", row_req, 1);
    wait_run("pause");
    chk("pause_rows_left", exp_rows.size(), 0);

    // Three generations, wrap mode: bank 0 -> 1 -> 0 -> 1.
    push_gen(1, 0);
    push_gen(1, 1);
    push_gen(1, 0);
    push_done(3, 1, 1);
    base = rq_cnt;
    do_start(3, 1);
    wait_run("gen3");
    chk("gen3_row_reqs", rq_cnt - base, 12);
    chk("gen3_rows_left", exp_rows.size(), 0);
    chk("gen3_gens_done", gens_done, 3);
    chk("gen3_read_bank", read_bank, 1);

    // Reset while waiting on row 2: no done pulse, everything cleared.
    push_gen(0, 1);
    base = done_cnt;
    do_start(1, 0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (row_req && calc_row == 2'd2) found = 1'b1;
    end
    chk("reach_row2", found, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    exp_rows.delete();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    chk("no_done_on_reset", done_cnt - base, 0);

    // Fresh run after reset starts at row 0 on bank 0.
    push_gen(0, 0);
    push_done(1, 1, 1);
    do_start(1, 0);
    @(negedge clk);
    chk("resume_row0", {row_req, calc_row}, 3'b100);
    wait_run("resume");
    chk("resume_rows_left", exp_rows.size(), 0);
    chk("done_left", exp_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
